// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer that drives a combinational 16-bit ALU.
// Shift-by-N is built from repeated single-bit ALU shifts. MUL (low 16 bits)
// is built from shift-and-add steps, and it exits early once no multiplier
// bits remain. The sequencer owns the ALU a/b/control inputs while busy.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_y
);

    localparam logic [1:0] OP_SHL = 2'd0;
    localparam logic [1:0] OP_SHR = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;
    localparam logic [3:0] ALU_SAR = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_MADD,
        S_MSHL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [3:0]       w_alu_control;
    logic [3:0]       w_shift_code;
    logic             w_ready;
    logic             w_done;
    logic [WIDTH-1:0] w_mplier_shr;

    assign w_mplier_shr = r_mplier >> 1;

    // Map the latched shift op onto the matching single-bit ALU opcode.
    always_comb begin
        w_shift_code = ALU_SAR;
        case (r_op)
            OP_SHL:  w_shift_code = ALU_SHL;
            OP_SHR:  w_shift_code = ALU_SHR;
            default: w_shift_code = ALU_SAR;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and ALU drive; the ALU sees zeros whenever it is not in use.
    always_comb begin
        w_state_next  = r_state;
        w_alu_a       = '0;
        w_alu_b       = '0;
        w_alu_control = ALU_ADD;
        w_ready       = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (start) begin
                    w_state_next = (op == OP_MUL) ? S_MADD : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != 4'd0) begin
                    w_alu_a       = r_work;
                    w_alu_control = w_shift_code;
                    if (r_cnt == 4'd1) begin
                        w_state_next = S_DONE;
                    end
                end else begin
                    // A zero count passes the operand straight through.
                    w_state_next = S_DONE;
                end
            end
            S_MADD: begin
                w_alu_a       = r_acc;
                w_alu_b       = r_mcand;
                w_alu_control = ALU_ADD;
                w_state_next  = S_MSHL;
            end
            S_MSHL: begin
                w_alu_a       = r_mcand;
                w_alu_control = ALU_SHL;
                // Stop as soon as no multiplier bits are left to consume.
                w_state_next  = (w_mplier_shr == '0) ? S_DONE : S_MADD;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture at accept, then ALU write-back per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        if (op == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= opa;
                            r_mplier <= opb;
                        end else begin
                            r_work <= opa;
                            r_cnt  <= opb[3:0];
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == 4'd0) begin
                        r_result <= r_work;
                    end else begin
                        r_work <= alu_y;
                        r_cnt  <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_result <= alu_y;
                        end
                    end
                end
                S_MADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_y;
                    end
                end
                S_MSHL: begin
                    r_mcand  <= alu_y;
                    r_mplier <= w_mplier_shr;
                    if (w_mplier_shr == '0) begin
                        r_result <= r_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready       = w_ready;
    assign done        = w_done;
    assign result      = r_result;
    assign zero        = (r_result == '0);
    assign sign        = r_result[WIDTH-1];
    assign alu_a       = w_alu_a;
    assign alu_b       = w_alu_b;
    assign alu_control = w_alu_control;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: a behavioural ALU sits on the a/b/control/y port.
// Results and latencies are checked against an arithmetic reference model.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        zero;
    logic        sign;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_control;
    logic [15:0] alu_y;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .sign        (sign),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_y       (alu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-bit ALU: combinational, no pipeline stage.
    always_comb begin
        case (alu_control)
            4'd0:    alu_y = alu_a + alu_b;
            4'd6:    alu_y = alu_a << 1;
            4'd7:    alu_y = alu_a >> 1;
            4'd8:    alu_y = {alu_a[15], alu_a[15:1]};
            default: alu_y = 16'h0000;
        endcase
    end

    // Reference result straight from the operation definitions.
    function automatic logic [15:0] model_result(input logic [1:0] mop, input logic [15:0] a,
                                                 input logic [15:0] b);
        logic signed [15:0] s;
        logic [31:0]        p;
        int                 n;
        n = int'(b[3:0]);
        s = a;
        case (mop)
            2'd0:    return a << n;
            2'd1:    return a >> n;
            2'd2:    return s >>> n;
            default: begin
                p = {16'h0000, a} * {16'h0000, b};
                return p[15:0];
            end
        endcase
    endfunction

    // Reference latency from the accepting edge to the done cycle.
    function automatic int model_lat(input logic [1:0] mop, input logic [15:0] b);
        int m;
        if (mop != 2'd3) begin
            return (b[3:0] == 4'd0) ? 1 : int'(b[3:0]);
        end
        m = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) m = i + 1;
        end
        if (m == 0) m = 1;
        return 2 * m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation once ready is seen, then follow it to its done pulse.
    task automatic run_op(input logic [1:0] mop, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic z, output logic sg,
                          output int lat, output int n_sar, output int n_ctrl,
                          output logic pulse_ok);
        int w;
        int cnt;
        w = 0;
        while (!ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        start = 1'b1;
        op    = mop;
        opa   = a;
        opb   = b;
        @(posedge clk); #1;
        start = 1'b0;
        opa   = 16'($urandom);
        opb   = 16'($urandom);
        cnt    = 0;
        n_sar  = 0;
        n_ctrl = 0;
        while (!done && cnt < 100) begin
            if (alu_control == 4'd8) n_sar++;
            if (alu_control != 4'd0) n_ctrl++;
            @(posedge clk); #1;
            cnt++;
        end
        lat = done ? cnt : -1;
        res = result;
        z   = zero;
        sg  = sign;
        @(posedge clk); #1;
        pulse_ok = !done && ready;
        $display("op=%0d a=%h b=%h -> result=%h zero=%0d sign=%0d latency=%0d",
                 mop, a, b, res, z, sg, lat);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[9];
    logic [15:0] r_res;
    logic        r_z;
    logic        r_sg;
    logic        r_pulse;
    int          r_lat;
    int          r_sar;
    int          r_ctrl;

    initial begin
        logic [1:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] er;
        int          dones;
        int          cyc;
        int          acc_cyc;
        int          rst_dones;
        logic        saw_ready;
        logic [15:0] first_res;
        logic [15:0] second_res;
        int          first_lat;
        int          second_lat;

        vecs[0] = '{2'd2, 16'h8001, 16'h0004, 16'hF800, 4};
        vecs[1] = '{2'd0, 16'h0001, 16'hFFFF, 16'h8000, 15};
        vecs[2] = '{2'd1, 16'h8000, 16'h0000, 16'h8000, 1};
        vecs[3] = '{2'd3, 16'h0123, 16'h0045, 16'h4E6F, 14};
        vecs[4] = '{2'd3, 16'h1234, 16'h0100, 16'h3400, 18};
        vecs[5] = '{2'd3, 16'hBEEF, 16'h0000, 16'h0000, 2};
        vecs[6] = '{2'd1, 16'hF0F0, 16'h0003, 16'h1E1E, 3};
        vecs[7] = '{2'd2, 16'h7FFF, 16'h000F, 16'h0000, 15};
        vecs[8] = '{2'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 32};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        opa   = 16'h0000;
        opb   = 16'h0000;
        #3;
        check("reset_ready",  32'(ready),       32'd1);
        check("reset_done",   32'(done),        32'd0);
        check("reset_result", 32'(result),      32'd0);
        check("reset_zero",   32'(zero),        32'd1);
        check("reset_sign",   32'(sign),        32'd0);
        check("reset_alu",    {alu_a, alu_b} | 32'(alu_control), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors; 5 then 6 also exercises a back-to-back restart.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_res, r_z, r_sg, r_lat, r_sar, r_ctrl, r_pulse);
            check($sformatf("vec%0d_result", i), 32'(r_res),   32'(vecs[i].exp_res));
            check($sformatf("vec%0d_zero", i),   32'(r_z),     32'(vecs[i].exp_res == 16'h0000));
            check($sformatf("vec%0d_sign", i),   32'(r_sg),    32'(vecs[i].exp_res[15]));
            check($sformatf("vec%0d_latency", i), 32'(r_lat),  32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_pulse", i),  32'(r_pulse), 32'd1);
            if (i == 0) check("sar_ctrl_cycles", 32'(r_sar), 32'd4);
            if (i == 2) check("n0_no_alu_shift", 32'(r_ctrl), 32'd0);
        end

        // start held high across a 15-cycle shift; operands change while busy.
        start = 1'b1;
        op    = 2'd0;
        opa   = 16'h0001;
        opb   = 16'hFFFF;
        @(posedge clk); #1;
        op        = 2'd3;
        opa       = 16'h0003;
        opb       = 16'h0005;
        dones     = 0;
        cyc       = 0;
        acc_cyc   = -1;
        saw_ready = 1'b0;
        first_res = 16'h0000;
        second_res = 16'h0000;
        first_lat  = -1;
        second_lat = -1;
        while (dones < 2 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_res = result;
                    first_lat = cyc;
                end else begin
                    second_res = result;
                    second_lat = cyc - acc_cyc;
                end
            end
            if (ready) begin
                saw_ready = 1'b1;
            end else if (saw_ready && acc_cyc < 0) begin
                acc_cyc = cyc;
                start   = 1'b0;
            end
        end
        start = 1'b0;
        $display("held start: dones=%0d first=%h@%0d second=%h lat=%0d",
                 dones, first_res, first_lat, second_res, second_lat);
        check("held_dones",      32'(dones),      32'd2);
        check("held_first_res",  32'(first_res),  32'h8000);
        check("held_first_lat",  32'(first_lat),  32'd15);
        check("held_second_res", 32'(second_res), 32'h000F);
        check("held_second_lat", 32'(second_lat), 32'd6);
        @(posedge clk); #1;

        // Reset asserted in the middle of a MUL aborts it without a done pulse.
        while (!ready) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        op    = 2'd3;
        opa   = 16'h1234;
        opb   = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_ready",  32'(ready),  32'd1);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_zero",   32'(zero),   32'd1);
        check("midrst_done",   32'(done),   32'd0);
        rst_dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) rst_dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) rst_dones++;
        end
        check("midrst_no_done", 32'(rst_dones), 32'd0);
        run_op(2'd3, 16'h0123, 16'h0045, r_res, r_z, r_sg, r_lat, r_sar, r_ctrl, r_pulse);
        check("postrst_result",  32'(r_res), 32'h4E6F);
        check("postrst_latency", 32'(r_lat), 32'd14);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if (rop == 2'd3) rb = rb >> $urandom_range(0, 16);
            er  = model_result(rop, ra, rb);
            run_op(rop, ra, rb, r_res, r_z, r_sg, r_lat, r_sar, r_ctrl, r_pulse);
            check($sformatf("rand%0d_result", i),  32'(r_res),   32'(er));
            check($sformatf("rand%0d_flags", i),   32'({r_z, r_sg}), 32'({er == 16'h0000, er[15]}));
            check($sformatf("rand%0d_latency", i), 32'(r_lat),   32'(model_lat(rop, rb)));
            check($sformatf("rand%0d_pulse", i),   32'(r_pulse), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
